// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin front end that shares one multi-cycle ALU between two requesters.
// Define ALU_ARB_TIMEOUT_EN to abort ALU commands that exceed TIMEOUT_CYCLES in BUSY.
module alu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [2:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [2:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [15:0] rsp0_result,
  output logic        rsp0_err,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp1_result,
  output logic        rsp1_err,
  output logic        alu_start,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic        alu_done,
  input  logic [15:0] alu_result
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic        prio;      // requester that wins when both are valid
  logic        tag;       // requester owning the in-flight command
  logic [2:0]  op_q;
  logic [7:0]  a_q;
  logic [7:0]  b_q;
  logic [15:0] result_q;

  logic        gnt_id;
  logic        accept;
  logic        rsp_ready_tag;
  logic        timeout_hit;
  logic [2:0]  acc_op;
  logic [7:0]  acc_a;
  logic [7:0]  acc_b;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("alu_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    gnt_id = 1'b0;
    if (req0_valid && req1_valid) gnt_id = prio;
    else if (req1_valid)          gnt_id = 1'b1;
    acc_op = gnt_id ? req1_op : req0_op;
    acc_a  = gnt_id ? req1_a  : req0_a;
    acc_b  = gnt_id ? req1_b  : req0_b;
  end

  assign accept        = (state == IDLE) && !reset && (req0_valid || req1_valid);
  assign req0_ready    = accept && !gnt_id;
  assign req1_ready    = accept && gnt_id;
  assign rsp_ready_tag = tag ? rsp1_ready : rsp0_ready;

  assign alu_op      = op_q;
  assign alu_a       = a_q;
  assign alu_b       = b_q;
  assign rsp0_valid  = (state == RESP) && !tag;
  assign rsp1_valid  = (state == RESP) && tag;
  assign rsp0_result = result_q;
  assign rsp1_result = result_q;

`ifdef ALU_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt;
  logic             err_q;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp0_err    = err_q;
  assign rsp1_err    = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (state == BUSY) begin
      cnt <= cnt + CNT_W'(1);
      if (!alu_done && timeout_hit) err_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp0_err    = 1'b0;
  assign rsp1_err    = 1'b0;
`endif

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
    if (reset) begin
      state     <= IDLE;
      prio      <= 1'b0;
      tag       <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      alu_start <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          tag  <= gnt_id;
          prio <= ~gnt_id;
          op_q <= acc_op;
          a_q  <= acc_a;
          b_q  <= acc_b;
          if (acc_op == 3'b000) begin
            result_q <= '0;
            state    <= RESP;
          end else begin
            alu_start <= 1'b1;
            state     <= BUSY;
          end
        end
        BUSY: begin
          // Done wins over a timeout landing on the same edge.
          if (alu_done) begin
            result_q  <= alu_result;
            alu_start <= 1'b0;
            state     <= RESP;
          end else if (timeout_hit) begin
            result_q  <= '0;
            alu_start <= 1'b0;
            state     <= RESP;
          end
        end
        RESP: if (rsp_ready_tag) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15, ALU cycles allowed in BUSY before abort (used only with ALU_ARB_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid (N=0,1)  input  1  requester N presents a command.
REQ-005 reqN_ready  output  1  arbiter accepts requester N command this cycle.
REQ-006 reqN_op  input  3  ALU opcode (000 no-op, 001 add, 010 and, 011 xor, 1xx multiply).
REQ-007 reqN_a, reqN_b  input  8 each  operands.
REQ-008 rspN_valid  output  1  response for requester N available.
REQ-009 rspN_ready  input  1  requester N consumes response.
REQ-010 rspN_result  output  16  result for requester N.
REQ-011 rspN_err  output  1  command aborted by timeout.
REQ-012 alu_start  output  1  ALU start, held until alu_done.
REQ-013 alu_op  output  3; alu_a, alu_b  output  8 each  ALU command fields.
REQ-014 alu_done  input  1; alu_result  input  16  ALU completion and result.

Function
REQ-015 FSM SHALL have states IDLE, BUSY, RESP; one command in flight at a time.
REQ-016 IDLE: if any reqN_valid, SHALL grant one requester; reqN_ready asserted combinationally only for the granted requester, only in IDLE.
REQ-017 Arbitration SHALL be round-robin: with both valid, grant the requester not granted at the last accept; after reset req0 wins.
REQ-018 On accept (valid&ready), SHALL register op, a, b and requester tag; pointer updates same edge.
REQ-019 Accepted op 000: SHALL go to RESP with result 0, err 0, alu_start never asserted.
REQ-020 Accepted op != 000: SHALL go to BUSY; alu_start=1 and alu_op/a/b = registered values, constant throughout BUSY.
REQ-021 BUSY: on edge where alu_done=1, SHALL capture alu_result and go to RESP; alu_start low from next cycle.
REQ-022 RESP: rsp[tag]_valid=1 with result/err held stable; other requester's rsp_valid=0; on rsp[tag]_ready go to IDLE.
REQ-023 alu_start SHALL be low for at least one cycle between consecutive ALU commands (RESP guarantees this).
REQ-024 alu_done outside BUSY SHALL be ignored.
REQ-025 Requests arriving during BUSY/RESP SHALL wait (ready=0); no command is dropped or reordered per requester.
REQ-026 Throughput: accept-to-next-accept minimum = ALU done latency + 2 cycles for non-no-op commands, 2 cycles for no-op.

Reset
REQ-027 reset SHALL force: state IDLE, pointer to req0, alu_start 0, alu_op/a/b 0, all rsp_valid 0, rsp_result 0, rsp_err 0, timeout counter 0.
REQ-028 Reset mid-operation SHALL drop the in-flight command with no response; alu_start low the cycle after reset is sampled.
REQ-029 reqN_ready SHALL be 0 while reset is high.

Configuration
REQ-030 Macro ALU_ARB_TIMEOUT_EN defined: counter clears on entry to BUSY, increments each BUSY cycle; at TIMEOUT_CYCLES without alu_done SHALL go to RESP with result 0, err 1.
REQ-031 alu_done and timeout on same edge: done SHALL win (normal result, err 0).
REQ-032 Macro undefined: no counter, rspN_err tied 0, BUSY waits indefinitely for alu_done.

Verification
REQ-033 req0 op=001 a=3 b=4 -> alu_start held until alu_done, rsp0_valid with result 7, err 0; rsp1_valid stays 0.
REQ-034 req0 and req1 valid same cycle after reset (req0 op=100 a=255 b=255, req1 op=011 a=0xF0 b=0xFF) -> req0 first result 0xFE01, then req1 result 0x000F.
REQ-035 req1 op=000 -> rsp1_valid result 0, alu_start never high.
REQ-036 rsp0_ready held 0 for 5 cycles -> rsp0_valid/result stable, req1 pending stays unaccepted until rsp0 handshake.
REQ-037 With ALU_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=15, alu_done tied 0 -> after 15 BUSY cycles rsp0_err=1, result 0; without macro FSM remains BUSY.
REQ-038 reset asserted during BUSY of a multiply -> no response, alu_start low next cycle, next command accepted normally.
